// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM shadow-compare block.
// No logic; the package is imported by the top and by the dead-time generator.
package pwm_pkg;

  localparam int PWM_WIDTH = 8;
  localparam int PWM_DT    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time generator: turns the raw compare into a non-overlapping complementary pair.
// Latency: a falling edge follows raw by 1 clk, and a rising edge follows the other output's fall by DT clk.
// Backpressure: none; a raw pulse that ends within the dead-time is swallowed.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int DT    = PWM_DT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic run,
  output logic p,
  output logic n
);

  // Counts cycles that both outputs have spent low since the last fall.
  logic [WIDTH-1:0] gap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p   <= 1'b0;
      n   <= 1'b0;
      gap <= '0;
    end else if (!run) begin
      p   <= 1'b0;
      n   <= 1'b0;
      gap <= '0;
    end else if (p && !raw) begin
      p   <= 1'b0;
      gap <= '0;
    end else if (n && raw) begin
      n   <= 1'b0;
      gap <= '0;
    end else if (!p && !n) begin
      // Both outputs are low: the side raw selects rises only once DT low cycles have elapsed.
      if (int'(gap) + 1 >= DT) begin
        p   <= raw;
        n   <= !raw;
        gap <= '0;
      end else begin
        gap <= gap + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_shadow_cmp.sv
// PWM compare with a double-buffered duty; defining DEADTIME_EN routes the outputs through pwm_deadtime.
// Latency: pwm_out follows cnt by one clk, and a new duty first governs the period that starts at cnt == 0.
// Backpressure: duty_ready stays low while the shadow holds a value that has not yet been applied.
module pwm_shadow_cmp
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
`ifdef DEADTIME_EN
  , parameter int DT = PWM_DT
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] period,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             update_ack,
  output logic             period_tick,
  output logic             pwm_out,
  output logic             pwm_n
);

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] active_duty;
  logic [WIDTH-1:0] last_cnt;
  logic             shadow_full;
  logic             accept;
  logic             cmp;
  pwm_state_e       state;

  // A period of 0 means the full 2^WIDTH modulus, so the subtraction is allowed to wrap.
  assign last_cnt    = period - WIDTH'(1);
  assign period_tick = enable && (cnt == last_cnt);
  assign accept      = duty_valid && duty_ready;
  assign cmp         = cnt < active_duty;

  // The shadow is applied only on the last count, so a running period is never cut short.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow      <= '0;
      active_duty <= '0;
      shadow_full <= 1'b0;
      duty_ready  <= 1'b0;
      update_ack  <= 1'b0;
    end else begin
      update_ack <= 1'b0;
      if (period_tick && shadow_full) begin
        active_duty <= shadow;
        shadow_full <= 1'b0;
        duty_ready  <= 1'b1;
        update_ack  <= 1'b1;
      end else if (accept) begin
        shadow      <= duty_in;
        shadow_full <= 1'b1;
        duty_ready  <= 1'b0;
      end else begin
        duty_ready  <= !shadow_full;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (!enable) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= SYNC;
        SYNC:    if (period_tick) state <= RUN;
        RUN:     state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEADTIME_EN
  logic run;

  assign run = enable && (state == RUN);

  pwm_deadtime #(
    .WIDTH (WIDTH),
    .DT    (DT)
  ) u_deadtime (
    .clk   (clk),
    .reset (reset),
    .raw   (cmp),
    .run   (run),
    .p     (pwm_out),
    .n     (pwm_n)
  );
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out <= 1'b0;
      pwm_n   <= 1'b0;
    end else if (enable && (state == RUN)) begin
      pwm_out <= cmp;
      pwm_n   <= !cmp;
    end else begin
      pwm_out <= 1'b0;
      pwm_n   <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_shadow_cmp.sv
// Directed bench for pwm_shadow_cmp with an upstream modulo counter model; follows DEADTIME_EN.
`timescale 1ns/1ps
module tb_pwm_shadow_cmp;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cnt;
  logic [7:0] period;
  logic       enable;
  logic [7:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       update_ack;
  logic       period_tick;
  logic       pwm_out;
  logic       pwm_n;

  int n_cmp = 0;
  int n_bad = 0;

  pwm_shadow_cmp dut (
    .clk         (clk),
    .reset       (reset),
    .cnt         (cnt),
    .period      (period),
    .enable      (enable),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .update_ack  (update_ack),
    .period_tick (period_tick),
    .pwm_out     (pwm_out),
    .pwm_n       (pwm_n)
  );

  always #5 clk = ~clk;

  // Upstream free-running modulo-period counter.
  always @(posedge clk or posedge reset) begin
    if (reset) cnt <= 8'd0;
    else       cnt <= (cnt == period - 8'd1) ? 8'd0 : cnt + 8'd1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cnt(input logic [7:0] v);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (cnt == v) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL wait_cnt: cnt=%0d never reached required %0d", cnt, v);
  endtask

  task automatic push(input logic [7:0] d);
    duty_in    = d;
    duty_valid = 1'b1;
    @(negedge clk);
    duty_valid = 1'b0;
  endtask

  task automatic measure(input int len, output int hi, output int nhi, output int acks, output int both);
    hi = 0; nhi = 0; acks = 0; both = 0;
    for (int i = 0; i < len; i++) begin
      hi   += int'(pwm_out);
      nhi  += int'(pwm_n);
      acks += int'(update_ack);
      both += int'(pwm_out & pwm_n);
      @(negedge clk);
    end
  endtask

  task automatic test_reset(input logic [7:0] per);
    reset = 1'b1; enable = 1'b0; duty_valid = 1'b0; duty_in = 8'd0; period = per;
    repeat (3) @(negedge clk);
    n_cmp++; if (duty_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", duty_ready); end
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL rst_pwm: got %b want 0", pwm_out); end
    n_cmp++; if (pwm_n !== 1'b0) begin n_bad++; $display("FAIL rst_pwm_n: got %b want 0", pwm_n); end
    n_cmp++; if (update_ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %b want 0", update_ack); end
    n_cmp++; if (period_tick !== 1'b0) begin n_bad++; $display("FAIL rst_tick: got %b want 0", period_tick); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (duty_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", duty_ready); end
  endtask

`ifndef DEADTIME_EN
  task automatic test_basic();
    int hi, nhi, acks, both;
    push(8'd3);
    n_cmp++; if (duty_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_drop: got %b want 0", duty_ready); end
    wait_cnt(8'd2);
    enable = 1'b1;
    wait_cnt(8'd9);
    n_cmp++; if (period_tick !== 1'b1) begin n_bad++; $display("FAIL basic_tick: got %b want 1", period_tick); end
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL basic_sync_low: got %b want 0", pwm_out); end
    @(negedge clk);
    n_cmp++; if (update_ack !== 1'b1) begin n_bad++; $display("FAIL basic_ack: got %b want 1", update_ack); end
    n_cmp++; if (duty_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_back: got %b want 1", duty_ready); end
    @(negedge clk);
    measure(10, hi, nhi, acks, both);
    n_cmp++; if (hi != 3) begin n_bad++; $display("FAIL basic_high: got %0d want 3", hi); end
    n_cmp++; if (nhi != 7) begin n_bad++; $display("FAIL basic_n_high: got %0d want 7", nhi); end
    n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL basic_single_ack: got %0d extra want 0", acks); end
  endtask

  task automatic test_boundaries();
    int hi, nhi, acks, both;
    push(8'd0);
    wait_cnt(8'd1);
    measure(10, hi, nhi, acks, both);
    n_cmp++; if (hi != 0) begin n_bad++; $display("FAIL duty0_high: got %0d want 0", hi); end
    n_cmp++; if (nhi != 10) begin n_bad++; $display("FAIL duty0_n_high: got %0d want 10", nhi); end
    push(8'd10);
    wait_cnt(8'd1);
    measure(30, hi, nhi, acks, both);
    n_cmp++; if (hi != 30) begin n_bad++; $display("FAIL duty10_high: got %0d want 30", hi); end
    n_cmp++; if (nhi != 0) begin n_bad++; $display("FAIL duty10_n_high: got %0d want 0", nhi); end
    push(8'd200);
    wait_cnt(8'd1);
    measure(30, hi, nhi, acks, both);
    n_cmp++; if (hi != 30) begin n_bad++; $display("FAIL duty200_high: got %0d want 30", hi); end
  endtask

  task automatic test_glitch_free();
    int hi, nhi, acks, both;
    push(8'd7);
    wait_cnt(8'd1);
    hi = 0; acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (cnt == 8'd4) begin
        duty_in = 8'd2; duty_valid = 1'b1;
      end else if (cnt == 8'd5) begin
        duty_valid = 1'b0;
        n_cmp++; if (duty_ready !== 1'b0) begin n_bad++; $display("FAIL glitch_ready: got %b want 0", duty_ready); end
      end else if (cnt == 8'd6) begin
        duty_in = 8'd9; duty_valid = 1'b1;
      end else if (cnt == 8'd8) begin
        duty_valid = 1'b0;
      end
      hi   += int'(pwm_out);
      acks += int'(update_ack);
      @(negedge clk);
    end
    n_cmp++; if (hi != 7) begin n_bad++; $display("FAIL glitch_current: got %0d want 7", hi); end
    n_cmp++; if (acks != 1) begin n_bad++; $display("FAIL glitch_ack: got %0d want 1", acks); end
    measure(10, hi, nhi, acks, both);
    n_cmp++; if (hi != 2) begin n_bad++; $display("FAIL glitch_next: got %0d want 2", hi); end
    measure(10, hi, nhi, acks, both);
    n_cmp++; if (hi != 2) begin n_bad++; $display("FAIL glitch_ignored_push: got %0d want 2", hi); end
  endtask

  task automatic test_back_to_back();
    int hi, nhi, acks, both;
    wait_cnt(8'd9);
    n_cmp++; if (duty_ready !== 1'b1) begin n_bad++; $display("FAIL simul_ready: got %b want 1", duty_ready); end
    duty_in = 8'd5; duty_valid = 1'b1;
    @(negedge clk);
    duty_valid = 1'b0;
    n_cmp++; if (update_ack !== 1'b0) begin n_bad++; $display("FAIL simul_no_ack: got %b want 0", update_ack); end
    n_cmp++; if (duty_ready !== 1'b0) begin n_bad++; $display("FAIL simul_captured: got %b want 0", duty_ready); end
    @(negedge clk);
    measure(10, hi, nhi, acks, both);
    n_cmp++; if (hi != 2) begin n_bad++; $display("FAIL simul_old_duty: got %0d want 2", hi); end
    n_cmp++; if (acks != 1) begin n_bad++; $display("FAIL simul_late_ack: got %0d want 1", acks); end
    measure(10, hi, nhi, acks, both);
    n_cmp++; if (hi != 5) begin n_bad++; $display("FAIL simul_new_duty: got %0d want 5", hi); end
  endtask

  task automatic test_enable_reset();
    int hi, nhi, acks, both;
    @(negedge clk);
    n_cmp++; if (pwm_out !== 1'b1) begin n_bad++; $display("FAIL en_mid_pulse: got %b want 1", pwm_out); end
    enable = 1'b0;
    @(negedge clk);
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL en_drop_pwm: got %b want 0", pwm_out); end
    n_cmp++; if (pwm_n !== 1'b0) begin n_bad++; $display("FAIL en_drop_pwm_n: got %b want 0", pwm_n); end
    wait_cnt(8'd4);
    enable = 1'b1;
    hi = 0;
    for (int i = 0; i < 7; i++) begin
      hi += int'(pwm_out) + int'(pwm_n);
      @(negedge clk);
    end
    n_cmp++; if (hi != 0) begin n_bad++; $display("FAIL en_sync_quiet: got %0d high samples want 0", hi); end
    n_cmp++; if (pwm_out !== 1'b1) begin n_bad++; $display("FAIL en_resume: got %b want 1", pwm_out); end
    push(8'd9);
    n_cmp++; if (duty_ready !== 1'b0) begin n_bad++; $display("FAIL rst_shadow_full: got %b want 0", duty_ready); end
    reset = 1'b1;
    #1;
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL rst_async_pwm: got %b want 0", pwm_out); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (duty_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", duty_ready); end
    wait_cnt(8'd9);
    wait_cnt(8'd1);
    measure(20, hi, nhi, acks, both);
    n_cmp++; if (hi != 0) begin n_bad++; $display("FAIL rst_discard_high: got %0d want 0", hi); end
    n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL rst_discard_ack: got %0d want 0", acks); end
    n_cmp++; if (nhi != 20) begin n_bad++; $display("FAIL rst_running_n: got %0d want 20", nhi); end
  endtask
`else
  task automatic test_deadtime();
    int hi, nhi, acks, both;
    push(8'd5);
    wait_cnt(8'd2);
    enable = 1'b1;
    wait_cnt(8'd0);
    wait_cnt(8'd0);
    measure(16, hi, nhi, acks, both);
    n_cmp++; if (both != 0) begin n_bad++; $display("FAIL dt_overlap: got %0d want 0", both); end
    n_cmp++; if (hi != 3) begin n_bad++; $display("FAIL dt_high: got %0d want 3", hi); end
    n_cmp++; if (nhi != 9) begin n_bad++; $display("FAIL dt_n_high: got %0d want 9", nhi); end
    wait_cnt(8'd4);
    n_cmp++; if (pwm_out !== 1'b1) begin n_bad++; $display("FAIL dt_mid_pulse: got %b want 1", pwm_out); end
    enable = 1'b0;
    @(negedge clk);
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL dt_drop_pwm: got %b want 0", pwm_out); end
    n_cmp++; if (pwm_n !== 1'b0) begin n_bad++; $display("FAIL dt_drop_pwm_n: got %b want 0", pwm_n); end
  endtask
`endif

  initial begin
`ifndef DEADTIME_EN
    test_reset(8'd10);
    test_basic();
    test_boundaries();
    test_glitch_free();
    test_back_to_back();
    test_enable_reset();
`else
    test_reset(8'd16);
    test_deadtime();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
